// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end sharing one 16-bit ALU
// Accepts one operation at a time, executes it in one cycle, holds the result until consumed.

module alu (
   input  logic [3:0]  op,
   input  logic [15:0] in_1,
   input  logic [15:0] in_2,
   output logic [15:0] result,
   output logic        zero
);

   localparam logic [3:0] F_ADD = 4'h0;
   localparam logic [3:0] F_SUB = 4'h1;
   localparam logic [3:0] F_AND = 4'h2;
   localparam logic [3:0] F_OR  = 4'h3;

   // SLT/SLTU and every other code fall into the default and produce zero.
   always_comb begin
      result = 16'h0000;
      case (op)
         F_ADD:   result = in_1 + in_2;
         F_SUB:   result = in_1 - in_2;
         F_AND:   result = in_1 & in_2;
         F_OR:    result = in_1 | in_2;
         default: result = 16'h0000;
      endcase
   end

   assign zero = (result == 16'h0000);

endmodule

module alu_arbiter #(
   parameter int RESET_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_in_1,
   input  logic [15:0] req0_in_2,
   input  logic [3:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_in_1,
   input  logic [15:0] req1_in_2,
   input  logic [3:0]  req1_op,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [15:0] rsp_data,
   output logic        rsp_zero,
   input  logic        rsp_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Pointer holds the last served index, so reset loads the opposite of RESET_PRIO.
   localparam logic RESET_LAST = (RESET_PRIO == 0) ? 1'b1 : 1'b0;

   state_t      state;
   state_t      next_state;
   logic        last_served;
   logic        grant_any;
   logic        grant_id;
   logic        accept;
   logic [3:0]  op_q;
   logic [15:0] in_1_q;
   logic [15:0] in_2_q;
   logic        id_q;
   logic [15:0] alu_result;
   logic        alu_zero;

   always_comb begin
      grant_any = 1'b0;
      grant_id  = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_any = 1'b1;
         grant_id  = ~last_served;
      end else if (req0_valid) begin
         grant_any = 1'b1;
         grant_id  = 1'b0;
      end else if (req1_valid) begin
         grant_any = 1'b1;
         grant_id  = 1'b1;
      end
   end

   // Reset masks acceptance so a valid seen during rst never leaves a ready pulse.
   assign accept = (state == IDLE) && grant_any && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = EXEC;
         EXEC:    next_state = RESP;
         RESP:    if (rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp_valid  = 1'b0;
      if (accept) begin
         req0_ready = ~grant_id;
         req1_ready = grant_id;
      end
      if (state == RESP) begin
         rsp_valid = 1'b1;
      end
   end

   alu u_alu (
      .op     (op_q),
      .in_1   (in_1_q),
      .in_2   (in_2_q),
      .result (alu_result),
      .zero   (alu_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         last_served <= RESET_LAST;
         op_q        <= 4'h0;
         in_1_q      <= 16'h0000;
         in_2_q      <= 16'h0000;
         id_q        <= 1'b0;
         rsp_data    <= 16'h0000;
         rsp_zero    <= 1'b0;
         rsp_id      <= 1'b0;
      end else begin
         if (accept) begin
            last_served <= grant_id;
            id_q        <= grant_id;
            if (grant_id) begin
               op_q   <= req1_op;
               in_1_q <= req1_in_1;
               in_2_q <= req1_in_2;
            end else begin
               op_q   <= req0_op;
               in_1_q <= req0_in_1;
               in_2_q <= req0_in_2;
            end
         end
         if (state == EXEC) begin
            rsp_data <= alu_result;
            rsp_zero <= alu_zero;
            rsp_id   <= id_q;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
// Vector table, directed multi-cycle sequences and a randomized transaction-level model.

module tb_alu_arbiter;

   localparam logic [3:0] F_ADD  = 4'h0;
   localparam logic [3:0] F_SUB  = 4'h1;
   localparam logic [3:0] F_AND  = 4'h2;
   localparam logic [3:0] F_OR   = 4'h3;
   localparam logic [3:0] F_SLT  = 4'h4;
   localparam logic [3:0] F_SLTU = 4'h5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [15:0] req0_in_1 = '0, req0_in_2 = '0, req1_in_1 = '0, req1_in_2 = '0;
   logic [3:0]  req0_op = '0, req1_op = '0;
   logic        rsp_valid, rsp_id, rsp_zero;
   logic [15:0] rsp_data;
   logic        rsp_ready = 1'b1;

   int checks = 0;
   int errors = 0;

   alu_arbiter #(.RESET_PRIO(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_in_1  (req0_in_1),
      .req0_in_2  (req0_in_2),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_in_1  (req1_in_1),
      .req1_in_2  (req1_in_2),
      .req1_op    (req1_op),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_zero   (rsp_zero),
      .rsp_ready  (rsp_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] data;
      logic        zero;
   } vec_t;

   vec_t vecs[10];

   function automatic logic [16:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      int unsigned r;
      case (op)
         F_ADD:   r = (int'(a) + int'(b)) % 65536;
         F_SUB:   r = (int'(a) - int'(b) + 65536) % 65536;
         F_AND:   r = a & b;
         F_OR:    r = a | b;
         default: r = 0;
      endcase
      return {(r == 0), r[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int id, input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      if (id == 0) begin
         req0_valid = v; req0_op = op; req0_in_1 = a; req0_in_2 = b;
      end else begin
         req1_valid = v; req1_op = op; req1_in_1 = a; req1_in_2 = b;
      end
   endtask

   // Called just after a negedge; leaves the bench at the negedge where the DUT is IDLE again.
   task automatic do_txn(input int id, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_d, input logic exp_z);
      rsp_ready = 1'b1;
      drive(id, 1'b1, op, a, b);
      #1 chk("txn_ready", {30'd0, req1_ready, req0_ready}, (id == 1) ? 32'd2 : 32'd1);
      @(negedge clk);
      drive(id, 1'b0, 4'($urandom), 16'($urandom), 16'($urandom));
      #1 chk("txn_exec_no_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      drive(id, 1'b0, 4'($urandom), 16'($urandom), 16'($urandom));
      #1;
      chk("txn_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("txn_rsp_data", {16'd0, rsp_data}, {16'd0, exp_d});
      chk("txn_rsp_zero", {31'd0, rsp_zero}, {31'd0, exp_z});
      chk("txn_rsp_id", {31'd0, rsp_id}, id);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic        m_pend;
      logic        m_last;
      int          m_acc;
      logic [16:0] m_exp;
      logic        m_id;
      logic        v0, v1, exp_any, exp_id, exp_rv;

      vecs[0] = '{F_ADD,  16'h0003, 16'h0004, 16'h0007, 1'b0};
      vecs[1] = '{F_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1};
      vecs[2] = '{F_SUB,  16'h0000, 16'h0001, 16'hFFFF, 1'b0};
      vecs[3] = '{F_AND,  16'h00FF, 16'h0F0F, 16'h000F, 1'b0};
      vecs[4] = '{F_OR,   16'h00F0, 16'h000F, 16'h00FF, 1'b0};
      vecs[5] = '{4'hF,   16'h1234, 16'h5678, 16'h0000, 1'b1};
      vecs[6] = '{F_SLT,  16'h0001, 16'h0002, 16'h0000, 1'b1};
      vecs[7] = '{F_SLTU, 16'h0001, 16'h0002, 16'h0000, 1'b1};
      vecs[8] = '{F_SUB,  16'h5555, 16'h5555, 16'h0000, 1'b1};
      vecs[9] = '{F_AND,  16'hF0F0, 16'h0F0F, 16'h0000, 1'b1};

      // Reset state with both requesters asserting valid.
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
      chk("reset_rsp_zero", {31'd0, rsp_zero}, 32'd0);
      chk("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst = 1'b0;

      // Vector table; the first transaction lands in the first cycle after reset.
      for (int i = 0; i < 10; i++) begin
         do_txn(i % 2, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].data, vecs[i].zero);
      end

      // Contention: grants 0,1,0,1 one every three cycles.
      do_reset();
      drive(0, 1'b1, F_ADD, 16'h0001, 16'h0002);
      drive(1, 1'b1, F_SUB, 16'h000A, 16'h0003);
      for (int k = 0; k < 12; k++) begin
         #1;
         chk("cont_ready", {30'd0, req1_ready, req0_ready},
             (k % 3 != 0) ? 32'd0 : (((k / 3) % 2 == 1) ? 32'd2 : 32'd1));
         chk("cont_rsp_valid", {31'd0, rsp_valid}, (k % 3 == 2) ? 32'd1 : 32'd0);
         if (k % 3 == 2) begin
            chk("cont_rsp_id", {31'd0, rsp_id}, (k / 3) % 2);
            chk("cont_rsp_data", {16'd0, rsp_data}, ((k / 3) % 2 == 1) ? 32'h7 : 32'h3);
         end
         @(negedge clk);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);

      // Backpressure: result held, no grants while RESP waits for rsp_ready.
      rsp_ready = 1'b0;
      drive(0, 1'b1, F_ADD, 16'h1111, 16'h2222);
      #1 chk("bp_accept", {30'd0, req1_ready, req0_ready}, 32'd1);
      @(negedge clk);
      drive(1, 1'b1, F_ADD, 16'h0001, 16'h0001);
      req0_in_1 = 16'hDEAD;
      #1 chk("bp_exec_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_hold_data", {16'd0, rsp_data}, 32'h3333);
         chk("bp_hold_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1 chk("bp_release_valid", {31'd0, rsp_valid}, 32'd1);
      @(negedge clk);
      #1 chk("bp_idle_grant_rr", {30'd0, req1_ready, req0_ready}, 32'd2);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("bp_second_data", {16'd0, rsp_data}, 32'h0002);
      chk("bp_second_id", {31'd0, rsp_id}, 32'd1);
      @(negedge clk);

      // Reset while req0 AND is in EXEC.
      drive(0, 1'b1, F_AND, 16'h00FF, 16'h0F0F);
      #1 chk("rm_accept", {30'd0, req1_ready, req0_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b1;
      #1;
      chk("rm_exec_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("rm_exec_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      #1;
      chk("rm_after_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rm_after_data", {16'd0, rsp_data}, 32'd0);
      chk("rm_after_zero", {31'd0, rsp_zero}, 32'd0);
      chk("rm_after_id", {31'd0, rsp_id}, 32'd0);
      chk("rm_after_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
      #1 chk("rm_still_no_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      do_txn(1, F_OR, 16'h00F0, 16'h000F, 16'h00FF, 1'b0);

      // Randomized traffic against a transaction-level model.
      do_reset();
      m_pend = 1'b0;
      m_last = 1'b1;
      m_acc  = 0;
      m_exp  = '0;
      m_id   = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         v0 = ($urandom_range(0, 99) < 60);
         v1 = ($urandom_range(0, 99) < 60);
         drive(0, v0, ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 6)), 16'($urandom), 16'($urandom));
         drive(1, v1, ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 6)), 16'($urandom), 16'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            req0_in_2 = req0_in_1;
            req1_in_2 = 16'(-int'(req1_in_1));
         end
         rsp_ready = ($urandom_range(0, 99) < 70);
         #1;
         exp_any = !m_pend && (v0 || v1);
         exp_id  = (v0 && v1) ? ~m_last : !v0;
         chk("rand_ready", {30'd0, req1_ready, req0_ready},
             !exp_any ? 32'd0 : (exp_id ? 32'd2 : 32'd1));
         exp_rv = m_pend && (cyc >= m_acc + 2);
         chk("rand_rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rv});
         if (exp_rv) begin
            chk("rand_rsp_data", {16'd0, rsp_data}, {16'd0, m_exp[15:0]});
            chk("rand_rsp_zero", {31'd0, rsp_zero}, {31'd0, m_exp[16]});
            chk("rand_rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
         end
         if (exp_rv && rsp_ready) begin
            m_pend = 1'b0;
         end
         if (exp_any) begin
            m_pend = 1'b1;
            m_acc  = cyc;
            m_id   = exp_id;
            m_last = exp_id;
            m_exp  = exp_id ? alu_ref(req1_op, req1_in_1, req1_in_2)
                            : alu_ref(req0_op, req0_in_1, req0_in_2);
         end
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
